// File: rtl/calc_arb_pkg.sv
// Shared types and constants for the two-requester calculator arbiter.
package calc_arb_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int OP_W        = 2;
    localparam int DEF_TIMEOUT = 15;
endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: a lone requester always wins, ptr breaks ties.
module arb_rr2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant,
    output logic       gidx
);
    always_comb begin
        gidx  = (valid == 2'b11) ? ptr : valid[1];
        grant = 2'b00;
        if (valid[gidx]) begin
            grant = gidx ? 2'b10 : 2'b01;
        end
    end
endmodule

// File: rtl/calc_arbiter.sv
// Shares one calculator between two requesters: round-robin accept, go/done
// sequencing, response hold and a watchdog that aborts and resets a hung calc.
module calc_arbiter
    import calc_arb_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [OP_W-1:0]  req_op0,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [OP_W-1:0]  req_op1,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             calc_go,
    output logic             calc_rst,
    output logic [OP_W-1:0]  calc_op,
    output logic [WIDTH-1:0] calc_a,
    output logic [WIDTH-1:0] calc_b,
    input  logic             calc_done,
    input  logic [WIDTH-1:0] calc_result
);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    state_t           state, state_nx;
    logic             ptr, owner;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       grant;
    logic             gidx;
    logic             accept, timeout_hit, rsp_take;

    arb_rr2 u_arb (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .gidx  (gidx)
    );

    assign accept      = (state == IDLE) && (grant != 2'b00);
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
    assign rsp_take    = (state == RESP) && rsp_ready[owner];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (calc_done || timeout_hit) state_nx = RESP;
            RESP:    if (rsp_take) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // req_ready is gated by rst so every output reads 0 while reset is held.
    always_comb begin
        req_ready = (state == IDLE && !rst) ? grant : 2'b00;
        calc_go   = (state == ISSUE);
        rsp_valid = 2'b00;
        if (state == RESP) rsp_valid = owner ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= 1'b0;
            owner    <= 1'b0;
            cnt      <= '0;
            calc_op  <= '0;
            calc_a   <= '0;
            calc_b   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            calc_rst <= 1'b0;
        end else begin
            calc_rst <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    owner   <= gidx;
                    calc_op <= gidx ? req_op1 : req_op0;
                    calc_a  <= gidx ? req_a1  : req_a0;
                    calc_b  <= gidx ? req_b1  : req_b0;
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    // Saturating count so a stuck compare can never wrap.
                    if (cnt != '1) cnt <= cnt + CNT_W'(1);
                    if (calc_done) begin
                        rsp_data <= calc_result;
                        rsp_err  <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        calc_rst <= 1'b1;
                    end
                end
                RESP: if (rsp_take) ptr <= ~owner;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_calc_arbiter.sv
// Directed bench for calc_arbiter with a 5-cycle add/sub calculator model.
module tb_calc_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_ready;
    logic [1:0] req_op0 = 2'b00, req_op1 = 2'b00;
    logic [3:0] req_a0 = 4'd0, req_b0 = 4'd0, req_a1 = 4'd0, req_b1 = 4'd0;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready = 2'b11;
    logic [3:0] rsp_data;
    logic       rsp_err;
    logic       calc_go, calc_rst, calc_done;
    logic [1:0] calc_op;
    logic [3:0] calc_a, calc_b, calc_result;

    logic       bfm_en = 1'b1;
    logic       spur_done = 1'b0;
    logic [2:0] bfm_cnt;
    int         nvec = 0;
    int         nerr = 0;

    always #5 clk = ~clk;

    calc_arbiter #(.WIDTH(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_a0(req_a0), .req_b0(req_b0),
        .req_op1(req_op1), .req_a1(req_a1), .req_b1(req_b1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .calc_go(calc_go), .calc_rst(calc_rst), .calc_op(calc_op),
        .calc_a(calc_a), .calc_b(calc_b),
        .calc_done(calc_done), .calc_result(calc_result)
    );

    // Calculator model: done pulses 5 cycles after go; spur_done forces a stray pulse with junk data.
    always @(posedge clk or posedge rst) begin
        if (rst)                    bfm_cnt <= 3'd0;
        else if (calc_go && bfm_en) bfm_cnt <= 3'd5;
        else if (bfm_cnt != 3'd0)   bfm_cnt <= bfm_cnt - 3'd1;
    end
    assign calc_done   = (bfm_cnt == 3'd1) | spur_done;
    assign calc_result = spur_done ? 4'hA :
                         (calc_op == 2'b01) ? (calc_a - calc_b) : (calc_a + calc_b);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 20 && rsp_valid == 2'b00; i++) tick();
    endtask

    task automatic run_txn(input string tag, input logic [1:0] exp_rdy, input logic [3:0] exp_data);
        chk({tag, "_ready"}, req_ready, exp_rdy);
        tick();
        chk({tag, "_go"}, calc_go, 1'b1);
        wait_rsp();
        chk({tag, "_rsp_valid"}, rsp_valid, exp_rdy);
        chk({tag, "_rsp_data"}, rsp_data, exp_data);
        chk({tag, "_rsp_err"}, rsp_err, 1'b0);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state, with both requesters already asking
        req_valid = 2'b11;
        #2;
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_calc_go", calc_go, 1'b0);
        chk("rst_calc_rst", calc_rst, 1'b0);
        chk("rst_calc_a", calc_a, 4'd0);
        chk("rst_rsp_data", rsp_data, 4'd0);
        tick();
        tick();
        rst = 1'b0;

        // 1: single request 3+4, exact latency, operand changes after accept ignored
        req_valid = 2'b01; req_op0 = 2'b00; req_a0 = 4'd3; req_b0 = 4'd4;
        #1;
        chk("t1_ready", req_ready, 2'b01);
        tick();
        chk("t1_ready_issue", req_ready, 2'b00);
        chk("t1_go", calc_go, 1'b1);
        chk("t1_calc_a", calc_a, 4'd3);
        chk("t1_calc_b", calc_b, 4'd4);
        req_valid = 2'b00; req_a0 = 4'd9; req_b0 = 4'd9;
        tick();
        chk("t1_go_drop", calc_go, 1'b0);
        repeat (4) tick();
        chk("t1_rsp_early", rsp_valid, 2'b00);
        tick();
        chk("t1_rsp_valid", rsp_valid, 2'b01);
        chk("t1_rsp_data", rsp_data, 4'd7);
        chk("t1_rsp_err", rsp_err, 1'b0);
        chk("t1_calc_a_held", calc_a, 4'd3);
        tick();
        chk("t1_rsp_clear", rsp_valid, 2'b00);

        // 2: contention after reset; 0 first, then 1, then 0 again
        do_reset();
        req_valid = 2'b11;
        req_op0 = 2'b00; req_a0 = 4'd2; req_b0 = 4'd5;
        req_op1 = 2'b01; req_a1 = 4'd9; req_b1 = 4'd3;
        #1;
        run_txn("t2a", 2'b01, 4'd7);
        run_txn("t2b", 2'b10, 4'd6);
        req_a0 = 4'd1; req_b0 = 4'd1;
        #1;
        run_txn("t2c", 2'b01, 4'd2);
        req_valid = 2'b00;

        // 3: hung calculator, watchdog abort TIMEOUT cycles after WAIT entry
        bfm_en = 1'b0;
        req_valid = 2'b01;
        #1;
        chk("t3_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        tick();
        repeat (14) tick();
        chk("t3_calc_rst_early", calc_rst, 1'b0);
        chk("t3_rsp_early", rsp_valid, 2'b00);
        tick();
        chk("t3_calc_rst", calc_rst, 1'b1);
        chk("t3_rsp_valid", rsp_valid, 2'b01);
        chk("t3_rsp_err", rsp_err, 1'b1);
        chk("t3_rsp_data", rsp_data, 4'd0);
        tick();
        chk("t3_calc_rst_pulse", calc_rst, 1'b0);
        chk("t3_rsp_clear", rsp_valid, 2'b00);
        bfm_en = 1'b1;

        // 4+5: backpressure on 3-5, stray done and non-owner ready during RESP
        rsp_ready = 2'b00;
        req_valid = 2'b10; req_op1 = 2'b01; req_a1 = 4'd3; req_b1 = 4'd5;
        #1;
        chk("t4_ready", req_ready, 2'b10);
        tick();
        req_valid = 2'b11;
        wait_rsp();
        chk("t4_rsp_valid", rsp_valid, 2'b10);
        for (int i = 0; i < 10; i++) begin
            spur_done = (i == 3);
            rsp_ready = (i == 6) ? 2'b01 : 2'b00;
            tick();
            chk("t4_hold_valid", rsp_valid, 2'b10);
            chk("t4_hold_data", rsp_data, 4'hE);
            chk("t4_hold_ready", req_ready, 2'b00);
        end
        spur_done = 1'b0;
        rsp_ready = 2'b10;
        tick();
        chk("t4_release", rsp_valid, 2'b00);
        chk("t4_idle_ready", req_ready, 2'b01);
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        chk("t5_idle_rsp", rsp_valid, 2'b00);
        chk("t5_idle_go", calc_go, 1'b0);
        chk("t5_idle_data", rsp_data, 4'hE);

        // Leave ptr at 1 so the reset below is visible in arbitration
        req_valid = 2'b01; req_a0 = 4'd2; req_b0 = 4'd2;
        #1;
        run_txn("t5_txn", 2'b01, 4'd4);

        // 6: async reset in WAIT, then normal service from requester 0
        req_valid = 2'b10; req_op1 = 2'b00; req_a1 = 4'd5; req_b1 = 4'd6;
        #1;
        chk("t6_ready", req_ready, 2'b10);
        tick();
        tick();
        tick();
        req_valid = 2'b11;
        rst = 1'b1;
        #1;
        chk("t6_rst_ready", req_ready, 2'b00);
        chk("t6_rst_calc_a", calc_a, 4'd0);
        chk("t6_rst_calc_b", calc_b, 4'd0);
        chk("t6_rst_rsp_valid", rsp_valid, 2'b00);
        chk("t6_rst_go", calc_go, 1'b0);
        chk("t6_rst_data", rsp_data, 4'd0);
        rst = 1'b0;
        req_op0 = 2'b00; req_a0 = 4'd3; req_b0 = 4'd4;
        #1;
        run_txn("t6_after", 2'b01, 4'd7);
        req_valid = 2'b00;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
